// File: rtl/jt900h_pkg.sv
// Shared encodings for the shift sequencer: operation codes, FSM states and
// operand-size helpers used by both the datapath and the control.
package jt900h_pkg;

  typedef enum logic [2:0] {
    OP_RLC = 3'd0,
    OP_RRC = 3'd1,
    OP_RL  = 3'd2,
    OP_RR  = 3'd3,
    OP_SLA = 3'd4,
    OP_SRA = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Byte wins if both size strobes are set; neither set means long.
  function automatic logic [31:0] size_mask(input logic bs, input logic ws);
    if (bs)      return 32'h0000_00ff;
    else if (ws) return 32'h0000_ffff;
    else         return 32'hffff_ffff;
  endfunction

  function automatic logic [31:0] size_top(input logic bs, input logic ws);
    if (bs)      return 32'h0000_0080;
    else if (ws) return 32'h0000_8000;
    else         return 32'h8000_0000;
  endfunction

  function automatic logic [4:0] decode_cnt(input logic [3:0] cnt);
    return (cnt == 4'd0) ? 5'd16 : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/jt900h_shift1.sv
// Combinational single-bit shift/rotate of a byte/word/long operand.
// Bits above the selected size pass through untouched.
module jt900h_shift1
  import jt900h_pkg::*;
(
  input  logic [31:0] value,
  input  logic        carry,
  input  op_e         op,
  input  logic        bs,
  input  logic        ws,
  output logic [31:0] shifted,
  output logic        carry_out
);

  logic [31:0] mask, top, sized;
  logic        msb_bit, fill;

  always_comb begin
    mask    = size_mask(bs, ws);
    top     = size_top(bs, ws);
    msb_bit = |(value & top);
    fill    = 1'b0;
    sized   = '0;
    // Even op codes shift left, odd ones shift right.
    if (!op[0]) begin
      case (op)
        OP_RLC:  fill = msb_bit;
        OP_RL:   fill = carry;
        default: fill = 1'b0;
      endcase
      sized     = {value[30:0], fill} & mask;
      carry_out = msb_bit;
    end else begin
      case (op)
        OP_RRC:  fill = value[0];
        OP_RR:   fill = carry;
        OP_SRA:  fill = msb_bit;
        default: fill = 1'b0;
      endcase
      sized     = ({1'b0, value[31:1]} & (mask >> 1)) | (fill ? top : 32'd0);
      carry_out = value[0];
    end
    shifted = sized | (value & ~mask);
  end

endmodule

// File: rtl/jt900h_shseq.sv
// Multi-bit shift/rotate sequencer: one bit per enabled clock, 1..16 bits.
// Define JT900H_SHSEQ_PV_EN to produce even parity of the result on v.
module jt900h_shseq
  import jt900h_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        bs,
  input  logic        ws,
  input  logic [3:0]  cnt,
  input  logic [31:0] din,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic        cout,
  output logic        n,
  output logic        z,
  output logic        v,
  output logic [31:0] dout
);

  state_e      st;
  op_e         op_r;
  logic        bs_r, ws_r;
  logic [31:0] acc;
  logic        acy;
  logic [4:0]  left;
  logic [31:0] sh;
  logic        sh_cy;
  logic [31:0] sized;

  jt900h_shift1 u_shift1 (
    .value     (acc),
    .carry     (acy),
    .op        (op_r),
    .bs        (bs_r),
    .ws        (ws_r),
    .shifted   (sh),
    .carry_out (sh_cy)
  );

  assign sized = sh & size_mask(bs_r, ws_r);

  // acc/acy hold the working operand so that dout and the flags only move on
  // shift edges, never on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      dout <= '0;
      cout <= 1'b0;
      n    <= 1'b0;
      z    <= 1'b1;
      v    <= 1'b0;
      acc  <= '0;
      acy  <= 1'b0;
      op_r <= OP_RLC;
      bs_r <= 1'b0;
      ws_r <= 1'b0;
      left <= '0;
    end else if (cen) begin
      case (st)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            st   <= ST_SHIFT;
            busy <= 1'b1;
            acc  <= din;
            acy  <= cin;
            op_r <= op_e'(op);
            bs_r <= bs;
            ws_r <= ws;
            left <= decode_cnt(cnt);
          end else begin
            st <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          acc  <= sh;
          acy  <= sh_cy;
          dout <= sh;
          cout <= sh_cy;
          n    <= |(sh & size_top(bs_r, ws_r));
          z    <= ~|sized;
`ifdef JT900H_SHSEQ_PV_EN
          v    <= ~^sized;
`else
          v    <= 1'b0;
`endif
          left <= left - 5'd1;
          if (left == 5'd1) begin
            st   <= ST_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: begin
          st   <= ST_IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
